// File: rtl/vjtag_cdc_arb.sv
// Round-robin scheduler sharing one vjtag_cdc request channel among NUM_REQ sources.
// Each accepted transfer is pulsed once, then the payload is held for a guard window.
module vjtag_cdc_arb #(
   parameter  int NUM_REQ     = 4,
   parameter  int WIDTH       = 8,
   parameter  int HOLD_CYCLES = 8,
   localparam int IDW         = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     cdc_req,
   output logic [IDW+WIDTH-1:0]     cdc_payload,
   output logic                     busy
);

   localparam int CW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [CW-1:0]    cnt;
   logic [IDW-1:0]   winner;
   logic             found;
   int               idx;

   // Search starts one past the last grant so every waiting source is reached within NUM_REQ rounds.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= IDW'(NUM_REQ - 1);
         cnt         <= '0;
         cdc_req     <= 1'b0;
         cdc_payload <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               cdc_payload <= {winner, req_data[int'(winner)*WIDTH +: WIDTH]};
               last_grant  <= winner;
               state       <= ISSUE;
               cdc_req     <= 1'b1;
               busy        <= 1'b1;
            end
            ISSUE: begin
               cdc_req <= 1'b0;
               cnt     <= CW'(HOLD_CYCLES - 1);
               state   <= HOLD;
            end
            HOLD: begin
               // The CDC gives no ack, so this count alone keeps the payload stable long enough.
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               cdc_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vjtag_cdc_arb.sv
// Directed bench for vjtag_cdc_arb: default instance plus a HOLD_CYCLES=1 instance.
module tb_vjtag_cdc_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  valid, ready;
   logic [31:0] data;
   logic        creq, busy;
   logic [9:0]  payload;

   logic [3:0]  valid1, ready1;
   logic [31:0] data1;
   logic        creq1, busy1;
   logic [9:0]  payload1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vjtag_cdc_arb #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_data(data),
      .req_ready(ready), .cdc_req(creq), .cdc_payload(payload), .busy(busy));

   vjtag_cdc_arb #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_data(data1),
      .req_ready(ready1), .cdc_req(creq1), .cdc_payload(payload1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid  = 4'b0;
      valid1 = 4'b0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      rst_n  = 1'b1;
      valid  = '0;
      valid1 = '0;
      data   = '0;
      data1  = '0;
      #2;
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_req", creq, 0);
      chk("rst_payload", payload, 0);
      chk("rst_ready", ready, 0);

      // Single requester 0 with 0xA5
      data  = 32'h000000A5;
      valid = 4'b0001;
      #1;
      chk("t1_ready", ready, 4'b0001);
      tick();
      valid = 4'b0000;
      #1;
      chk("t1_pulse", creq, 1);
      chk("t1_payload", payload, 10'h0A5);
      chk("t1_busy_issue", busy, 1);
      chk("t1_ready_issue", ready, 0);
      for (int i = 2; i <= 9; i++) begin
         tick();
         chk("t1_hold_busy", busy, 1);
         chk("t1_hold_req", creq, 0);
      end
      tick();
      chk("t1_idle", busy, 0);
      chk("t1_payload_kept", payload, 10'h0A5);

      // All four valid: grants 0,1,2,3,0 every 10 cycles
      do_reset();
      data  = 32'h43322110;
      valid = 4'b1111;
      begin
         logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         logic [9:0] exp_pl  [5] = '{10'h010, 10'h121, 10'h232, 10'h343, 10'h010};
         for (int g = 0; g < 5; g++) begin
            #1;
            chk("t2_grant", ready, exp_rdy[g]);
            tick();
            chk("t2_pulse", creq, 1);
            chk("t2_payload", payload, exp_pl[g]);
            for (int i = 2; i <= 10; i++) begin
               tick();
               chk("t2_no_pulse", creq, 0);
            end
         end
      end

      // Requester 2 alone, then requester 1 joins during HOLD
      do_reset();
      data  = 32'h00C3B200;
      valid = 4'b0100;
      for (int g = 0; g < 2; g++) begin
         #1;
         chk("t3_grant2", ready, 4'b0100);
         tick();
         chk("t3_pulse", creq, 1);
         chk("t3_payload", payload, 10'h2C3);
         for (int i = 2; i <= 10; i++) begin
            tick();
            if (g == 1 && i == 4) valid = 4'b0110;
         end
      end
      #1;
      chk("t3_grant1", ready, 4'b0010);
      tick();
      valid = 4'b0100;
      chk("t3_payload1", payload, 10'h1B2);

      // HOLD_CYCLES=1 instance: pulses 3 cycles apart
      do_reset();
      data1  = 32'h00006B5A;
      valid1 = 4'b0011;
      #1;
      chk("t4_grant0", ready1, 4'b0001);
      tick();
      valid1 = 4'b0010;
      chk("t4_pulse0", creq1, 1);
      chk("t4_payload0", payload1, 10'h05A);
      tick();
      chk("t4_gap_req", creq1, 0);
      chk("t4_gap_payload", payload1, 10'h05A);
      tick();
      chk("t4_gap2_req", creq1, 0);
      chk("t4_gap2_payload", payload1, 10'h05A);
      chk("t4_grant1", ready1, 4'b0010);
      tick();
      valid1 = 4'b0000;
      chk("t4_pulse1", creq1, 1);
      chk("t4_payload1", payload1, 10'h16B);

      // Asynchronous reset mid-HOLD
      do_reset();
      data  = 32'h77000055;
      valid = 4'b0001;
      tick();
      valid = 4'b0000;
      tick();
      tick();
      #2;
      chk("t5_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy_clr", busy, 0);
      chk("t5_payload_clr", payload, 0);
      chk("t5_req_clr", creq, 0);
      tick();
      valid = 4'b1001;
      #1;
      rst_n = 1'b1;
      #1;
      chk("t5_grant0", ready, 4'b0001);
      tick();
      valid = 4'b1000;
      chk("t5_payload", payload, 10'h055);

      // Requester 1 drops valid during HOLD and never returns
      do_reset();
      data  = 32'h00002211;
      valid = 4'b0001;
      tick();
      valid = 4'b0010;
      tick();
      tick();
      valid = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i >= 8) begin
            chk("t6_no_ready", ready, 0);
            chk("t6_no_req", creq, 0);
            chk("t6_idle", busy, 0);
         end
      end
      chk("t6_payload", payload, 10'h011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vjtag_cdc_arb.md
Name: vjtag_cdc_arb

Overview:
- Single-clock scheduler that shares one vjtag_cdc handshake channel between NUM_REQ requesters in the source clock domain.
- Round-robin arbitration between requesters. Latches the winner's data tagged with its source index, then issues a one-cycle request pulse to the CDC.
- Holds the payload stable for a guard window so the CDC's handshake completes before the next transfer.
- The CDC exposes no busy or ack on the source side, so the hold counter is the only mechanism that prevents request overrun.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, data width per requester.
- HOLD_CYCLES, 8, cycles the payload is held after the request pulse; minimum 1. The integrator sets it to at least 2 clkb periods + 1 clkb period + 3 clk periods, expressed in clk cycles, with margin.
- IDW, $clog2(NUM_REQ), localparam: width of the source-index tag.

Ports:
- clk, input, 1: source-domain clock; same clock as the CDC's clka.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_REQ: per-requester valid.
- req_data, input, NUM_REQ*WIDTH: packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready, output, NUM_REQ: per-requester accept, one-hot or zero.
- cdc_req, output, 1: one-cycle request pulse, driven to the CDC's req_clka.
- cdc_payload, output, IDW+WIDTH: {source index, data}, driven to the CDC's payload_clka.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state = IDLE; cdc_req = 0; cdc_payload = 0; busy = 0; hold counter = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has priority first.
- States: IDLE, ISSUE, HOLD.
- IDLE:
  - Winner = first requester with req_valid set, searching from last_grant+1 upward with wrap-around.
  - req_ready[winner] = 1 combinationally in this same cycle; all other ready bits = 0.
  - At the clock edge: cdc_payload <= {winner index, req_data[winner]}; last_grant <= winner; state goes to ISSUE.
  - No valid requester: stay in IDLE, req_ready = 0.
- ISSUE:
  - cdc_req = 1 for exactly this cycle.
  - Hold counter <= HOLD_CYCLES-1; state goes to HOLD.
- HOLD:
  - cdc_req = 0; counter decrements each cycle.
  - When counter == 0, state goes to IDLE on the next edge.
- req_ready is 0 in ISSUE and HOLD.
- Latency:
  - Accept to cdc_req: 1 cycle.
  - cdc_payload changes only at accept edges. It is stable from the ISSUE cycle through the last HOLD cycle and remains stable in IDLE until the next accept.
  - Back-to-back throughput: one transfer per HOLD_CYCLES+2 cycles.
- Handshake rules:
  - Standard valid/ready; a transfer occurs when req_valid[i] & req_ready[i].
  - A requester keeps valid and data stable until accepted.
  - If valid drops before acceptance, nothing is recorded and no pulse is issued.
- Simultaneous requests: exactly one is granted per arbitration. A requester that keeps valid asserted is granted within NUM_REQ arbitrations (no starvation).
- Single active requester: it is granted every arbitration; the pointer does not penalise it.
- Reset mid-operation (ISSUE or HOLD): return immediately to IDLE with the reset values above. The in-flight transfer is abandoned by the scheduler, and the CDC is reset alongside it.
- busy = (state != IDLE), registered-equivalent with no glitch across state changes.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0xA5 on requester 0:
  - req_ready=0001 in the same cycle.
  - Next cycle cdc_req=1 and cdc_payload={2'd0,8'hA5}.
  - busy high for 1+8 cycles; IDLE again 10 cycles after accept.
- All four valid continuously, data 0x10/0x21/0x32/0x43:
  - Grants in order 0,1,2,3,0.
  - cdc_req pulses spaced exactly 10 cycles apart.
  - Payloads 0x010, 0x121, 0x232, 0x343, then 0x010 (index in the top 2 bits).
- Requester 2 alone valid repeatedly: granted every 10 cycles. Then requester 1 raises valid during HOLD: requester 1 wins the next arbitration (search starts at 3, wraps to 0, then 1).
- HOLD_CYCLES=1: pulses from back-to-back requests are 3 cycles apart. cdc_payload is unchanged between the pulse and the next accept.
- rst_n asserted asynchronously mid-HOLD:
  - Outputs clear with no clock edge needed.
  - After release with requesters 0 and 3 valid, requester 0 is granted first.
- Requester 1 drops valid while the block is in HOLD and never re-asserts: no req_ready[1] and no cdc_req are issued for it; the block idles.
